// File: rtl/mul_share_pkg.sv
// mul_share_pkg: shared types and constants for the multiplier-sharing arbiter.
//   state_e      : sequencer states (QUIET, IDLE, ISSUE, LAUNCH, WAIT, RESP)
//   WIDTH_DEF    : default operand/result width
//   QUIET_DEF    : default idle cycles after reset release before first issue
//   idx_w()      : bit width needed to hold a requester index
package mul_share_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned QUIET_DEF = 3;

    typedef enum logic [2:0] {
        ST_QUIET  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_WAIT   = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    // At least one bit, so a 2-requester build still has a usable index.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_share_arb_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req_i     : request vector, one bit per requester
//   ptr_i     : highest-priority requester index this round
//   gnt_id_o  : first set request at or after ptr_i, wrapping modulo N_REQ
//   any_req_o : high when at least one request bit is set
module rr_pick
    import mul_share_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [IW-1:0]    gnt_id_o,
    output logic             any_req_o
);

    // Walk offsets from the farthest to the nearest; the last hit written
    // is the closest one to the pointer, so no early exit is needed.
    always_comb begin
        gnt_id_o  = '0;
        any_req_o = 1'b0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (req_i[IW'((int'(ptr_i) + k) % int'(N_REQ))]) begin
                gnt_id_o  = IW'((int'(ptr_i) + k) % int'(N_REQ));
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin arbiter/sequencer sharing one start/done
// multiplier between N_REQ requesters.
//   clk, reset        : rising-edge clock, asynchronous active-low reset
//   req               : per-requester request level, held until its rsp_valid
//   req_a, req_b      : packed operands, slice i belongs to requester i
//   rsp_valid         : one-hot, one-cycle completion pulse
//   rsp_result        : product, valid while any rsp_valid bit is set
//   busy              : high from grant through the response cycle
//   mul_start/a/b     : to the shared multiplier
//   mul_result/done   : from the shared multiplier; done is a level that
//                       stays high until the next operation clears it
//
// Handshake: a requester raises req with stable operands and holds it until
// it sees its rsp_valid bit; rsp_valid/rsp_result are valid for exactly one
// cycle. Towards the multiplier, start is a one-cycle pulse, operands stay
// constant until the next grant, and done is only trusted in WAIT.
//
// The current FSM state is exposed on state_o for observation.
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned QUIET = QUIET_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_result,
    output logic                   busy,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic [WIDTH-1:0]       mul_result,
    input  logic                   mul_done,
    output state_e                 state_o
);

    localparam int unsigned IW = idx_w(N_REQ);
    localparam int unsigned QW = (QUIET < 1) ? 1 : $clog2(QUIET + 1);

    state_e             state_q;
    logic [QW-1:0]      quiet_cnt_q;
    logic [IW-1:0]      ptr_q;
    logic [IW-1:0]      ptr_d;
    logic [IW-1:0]      gnt_q;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic [WIDTH-1:0]   rsp_result_q;
    logic               busy_q;
    logic               mul_start_q;
    logic [WIDTH-1:0]   mul_a_q;
    logic [WIDTH-1:0]   mul_b_q;

    logic [IW-1:0]      pick_id;
    logic               any_req;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [N_REQ-1:0]   gnt_onehot;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .gnt_id_o  (pick_id),
        .any_req_o (any_req)
    );

    // Operand mux for the requester the picker is offering this cycle.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (pick_id == IW'(i)) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign gnt_onehot = N_REQ'(1) << gnt_q;

    // Next round starts just after the requester that was served.
    assign ptr_d = (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_QUIET;
            quiet_cnt_q  <= QW'(QUIET);
            ptr_q        <= '0;
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            busy_q       <= 1'b0;
            mul_start_q  <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
        end else begin
            case (state_q)
                // Gives a multiplier that was mid-operation at reset time
                // a chance to drain before we drive it.
                ST_QUIET: begin
                    if (quiet_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        quiet_cnt_q <= quiet_cnt_q - 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_q       <= pick_id;
                        mul_a_q     <= a_sel;
                        mul_b_q     <= b_sel;
                        busy_q      <= 1'b1;
                        mul_start_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mul_start_q <= 1'b0;
                    state_q     <= ST_LAUNCH;
                end
                // done may still be high from the previous operation here,
                // so it is deliberately not looked at.
                ST_LAUNCH: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mul_done) begin
                        rsp_result_q <= mul_result;
                        rsp_valid_q  <= gnt_onehot;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rsp_valid_q <= '0;
                    busy_q      <= 1'b0;
                    ptr_q       <= ptr_d;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_QUIET;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign busy       = busy_q;
    assign mul_start  = mul_start_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_mul_share_arb.sv
module tb_mul_share_arb;
  import mul_share_pkg::*;

  localparam int N = 4;
  localparam int W = 32;
  localparam int Q = 3;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_result;
  logic           busy;
  logic           mul_start;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [W-1:0]   mul_result;
  logic           mul_done;
  state_e         state_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int rel_cyc = 0;
  logic [W-1:0] exp_q[$];

  mul_share_arb #(.N_REQ(N), .WIDTH(W), .QUIET(Q)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .busy       (busy),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .mul_done   (mul_done),
    .state_o    (state_o)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: accept start, sample operands one edge later, result
  // and done one edge after that. slow_clr keeps done high one extra cycle.
  logic         slow_clr;
  logic [1:0]   ph;
  logic [W-1:0] la, lb;
  initial begin
    mul_done   = 1'b1;
    mul_result = '0;
    ph         = 2'd0;
    slow_clr   = 1'b0;
    la         = '0;
    lb         = '0;
  end
  always @(posedge clk) begin
    if (mul_start) begin
      acc_cyc <= cyc + 1;
      ph      <= 2'd1;
      if (!slow_clr) mul_done <= 1'b0;
    end else if (ph == 2'd1) begin
      la       <= mul_a;
      lb       <= mul_b;
      mul_done <= 1'b0;
      ph       <= 2'd2;
    end else if (ph == 2'd2) begin
      mul_result <= la * lb;
      mul_done   <= 1'b1;
      ph         <= 2'd0;
    end
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_rsp_valid"},  W'(rsp_valid), '0);
    check_eq({tag, "_rsp_result"}, rsp_result,    '0);
    check_eq({tag, "_busy"},       W'(busy),      '0);
    check_eq({tag, "_mul_start"},  W'(mul_start), '0);
    check_eq({tag, "_mul_a"},      mul_a,         '0);
    check_eq({tag, "_mul_b"},      mul_b,         '0);
  endtask

  // Called at a negedge. Waits for a response, checks it, drops the request.
  task automatic wait_rsp(input string tag, input int exp_id, input logic [W-1:0] exp_res,
                          output int rsp_cyc);
    logic [N-1:0] ev;
    int k;
    ev = N'(1) << exp_id;
    k  = 0;
    while (rsp_valid == '0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (rsp_valid == '0) begin
      check_eq({tag, "_timeout"}, 0, 1);
    end else begin
      check_eq({tag, "_rsp_valid"}, W'(rsp_valid), W'(ev));
      check_eq({tag, "_rsp_result"}, rsp_result, exp_res);
      check_eq({tag, "_latency"}, W'(cyc - acc_cyc), 3);
      check_eq({tag, "_busy"}, W'(busy), 1);
    end
    rsp_cyc = cyc;
    req[exp_id] = 1'b0;
  endtask

  task automatic pulse_reset_release();
    @(negedge clk);
    reset = 1'b1;
    rel_cyc = cyc;
  endtask

  int t0, t1, t2, t3;

  initial begin
    reset = 1'b0;
    req   = '0;
    req_a = '0;
    req_b = '0;

    // 1: reset state, first transaction after quiet period
    set_op(0, 32'd7, 32'd6);
    req = 4'b0001;
    #1;
    check_reset_outs("t1_reset");
    @(negedge clk);
    pulse_reset_release();
    wait_rsp("t1", 0, 32'd42, t0);
    check_eq("t1_quiet_start", W'(acc_cyc - rel_cyc), W'(Q + 3));
    @(negedge clk);
    check_eq("t1_after_valid", W'(rsp_valid), '0);
    check_eq("t1_after_busy", W'(busy), '0);

    // 2: all four requesting from reset, RR order 0..3, 6 cycles apart
    reset = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      set_op(i, W'(i + 1), 32'd10);
      exp_q.push_back(W'(10 * (i + 1)));
    end
    req = 4'b1111;
    @(negedge clk);
    pulse_reset_release();
    t0 = 0;
    for (int i = 0; i < N; i++) begin
      wait_rsp($sformatf("t2_r%0d", i), i, exp_q.pop_front(), t1);
      if (i > 0) check_eq($sformatf("t2_gap%0d", i), W'(t1 - t0), 6);
      t0 = t1;
      @(negedge clk);
    end

    // 3: serve 1 so the pointer sits at 2, then 0 must win over 1
    set_op(1, 32'd3, 32'd5);
    req = 4'b0010;
    wait_rsp("t3_first", 1, 32'd15, t1);
    set_op(0, 32'd11, 32'd2);
    set_op(1, 32'd4, 32'd4);
    req = 4'b0011;
    @(negedge clk);
    wait_rsp("t3_wrap0", 0, 32'd22, t2);
    @(negedge clk);
    wait_rsp("t3_wrap1", 1, 32'd16, t3);
    check_eq("t3_gap", W'(t3 - t2), 6);
    @(negedge clk);

    // 4: done stays high through ISSUE/LAUNCH; no early response
    slow_clr = 1'b1;
    set_op(2, 32'd5, 32'd9);
    req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    check_eq("t4_issue_no_rsp", W'(rsp_valid), '0);
    check_eq("t4_issue_done_hi", W'(mul_done), 1);
    @(negedge clk);
    check_eq("t4_launch_no_rsp", W'(rsp_valid), '0);
    wait_rsp("t4", 2, 32'd45, t1);
    slow_clr = 1'b0;
    @(negedge clk);

    // 5: reset while in WAIT aborts; re-issued request completes
    set_op(0, 32'd3, 32'd4);
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_eq("t5_busy_in_wait", W'(busy), 1);
    reset = 1'b0;
    #1;
    check_reset_outs("t5_async");
    set_op(0, 32'd5, 32'd4);
    @(negedge clk);
    pulse_reset_release();
    wait_rsp("t5_reissue", 0, 32'd20, t1);
    check_eq("t5_quiet_start", W'(acc_cyc - rel_cyc), W'(Q + 3));
    @(negedge clk);

    // 6: truncated product passes through unchanged
    set_op(3, 32'hFFFF_FFFF, 32'd2);
    req = 4'b1000;
    wait_rsp("t6", 3, 32'hFFFF_FFFE, t1);
    @(negedge clk);
    check_eq("t6_after_valid", W'(rsp_valid), '0);
    check_eq("t6_after_busy", W'(busy), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
